// File: rtl/vlg_gray_conv.sv
// Pipelined binary<->Gray converter (mode per beat), latency PIPE cycles.
// Backpressure: stages collapse bubbles; o_rdy drops only when every stage is full and the output stalls.
module vlg_gray_conv #(
    parameter int DATA_W = 8,
    parameter int PIPE   = 2,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    output logic              o_rdy,
    input  logic              i_mode,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic [DATA_W-1:0] o_data,
    output logic              o_mode,
    output logic [CNT_W-1:0]  o_cnt
);

    function automatic logic [DATA_W-1:0] gray2bin(input logic [DATA_W-1:0] g);
        logic [DATA_W-1:0] b;
        b = g;
        for (int k = DATA_W - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    logic [DATA_W-1:0] conv_dat;
    logic [PIPE-1:0]   stg_vld;
    logic [PIPE-1:0]   stg_mode;
    logic [DATA_W-1:0] stg_dat [PIPE];
    logic [PIPE-1:0]   can_load;
    logic              full_tail;

    assign conv_dat = i_mode ? gray2bin(i_data) : (i_data ^ (i_data >> 1));

    // A stage can take new contents unless it and everything after it is full and the output is stalled.
    always_comb begin
        can_load  = '0;
        full_tail = 1'b1;
        for (int i = 0; i < PIPE; i++) begin
            full_tail = 1'b1;
            for (int j = i; j < PIPE; j++) begin
                full_tail = full_tail & stg_vld[j];
            end
            can_load[i] = !full_tail || i_rdy;
        end
    end

    for (genvar g = 0; g < PIPE; g++) begin : g_stage
        logic              in_vld;
        logic              in_mode;
        logic [DATA_W-1:0] in_dat;
        logic              vld_q;
        logic              mode_q;
        logic [DATA_W-1:0] dat_q;

        if (g == 0) begin : g_first
            assign in_vld  = i_en;
            assign in_mode = i_mode;
            assign in_dat  = conv_dat;
        end else begin : g_rest
            assign in_vld  = stg_vld[g-1];
            assign in_mode = stg_mode[g-1];
            assign in_dat  = stg_dat[g-1];
        end

        // Payload only moves with a valid beat so o_data/o_mode keep their last value when idle.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                vld_q  <= 1'b0;
                mode_q <= 1'b0;
                dat_q  <= '0;
            end else if (can_load[g]) begin
                vld_q <= in_vld;
                if (in_vld) begin
                    mode_q <= in_mode;
                    dat_q  <= in_dat;
                end
            end
        end

        assign stg_vld[g]  = vld_q;
        assign stg_mode[g] = mode_q;
        assign stg_dat[g]  = dat_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_cnt <= '0;
        end else if (o_vld && i_rdy) begin
            o_cnt <= o_cnt + CNT_W'(1);
        end
    end

    assign o_rdy  = can_load[0];
    assign o_vld  = stg_vld[PIPE-1];
    assign o_mode = stg_mode[PIPE-1];
    assign o_data = stg_dat[PIPE-1];

endmodule

// File: tb/tb_vlg_gray_conv.sv
// Directed bench for vlg_gray_conv: three instances cover 8b/PIPE2, 32b/PIPE4/CNT4 and 2b/PIPE1.
module tb_vlg_gray_conv;

    typedef struct packed {
        logic        mode;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic rst_n;

    logic       a_en, a_mode, a_rdy, a_ordy, a_vld, a_omode;
    logic [7:0] a_data, a_odata;
    logic [15:0] a_cnt;

    logic        b_en, b_mode, b_rdy, b_ordy, b_vld, b_omode;
    logic [31:0] b_data, b_odata;
    logic [3:0]  b_cnt;

    logic        c_en, c_mode, c_rdy, c_ordy, c_vld, c_omode;
    logic [1:0]  c_data, c_odata;
    logic [15:0] c_cnt;

    vlg_gray_conv #(.DATA_W(8), .PIPE(2), .CNT_W(16)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(a_en), .o_rdy(a_ordy), .i_mode(a_mode),
        .i_data(a_data), .o_vld(a_vld), .i_rdy(a_rdy), .o_data(a_odata),
        .o_mode(a_omode), .o_cnt(a_cnt));

    vlg_gray_conv #(.DATA_W(32), .PIPE(4), .CNT_W(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(b_en), .o_rdy(b_ordy), .i_mode(b_mode),
        .i_data(b_data), .o_vld(b_vld), .i_rdy(b_rdy), .o_data(b_odata),
        .o_mode(b_omode), .o_cnt(b_cnt));

    vlg_gray_conv #(.DATA_W(2), .PIPE(1), .CNT_W(16)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(c_en), .o_rdy(c_ordy), .i_mode(c_mode),
        .i_data(c_data), .o_vld(c_vld), .i_rdy(c_rdy), .o_data(c_odata),
        .o_mode(c_omode), .o_cnt(c_cnt));

    int checks = 0;
    int failures = 0;
    bit mon_on = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_beat;
    vec_t a_tab[9];
    vec_t c_tab[8];
    bit stale;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] g8(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    // Scoreboard for instance A: each output transfer must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (mon_on && rst_n && a_vld && a_rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_extra_beat actual=%0h required=none", {a_omode, a_odata});
            end else begin
                exp_beat = exp_q.pop_front();
                chk("a_out", {a_omode, a_odata}, exp_beat);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_a(input logic m, input logic [7:0] d, input logic [7:0] e, input bit push);
        bit took;
        took = 1'b0;
        a_en = 1'b1;
        a_mode = m;
        a_data = d;
        for (int n = 0; n < 100 && !took; n++) begin
            @(negedge clk);
            took = a_ordy;
            @(posedge clk);
            #1;
        end
        if (!took) begin
            checks++;
            failures++;
            $display("FAIL a_send_timeout actual=blocked required=accepted");
        end else if (push) begin
            exp_q.push_back({m, e});
        end
    endtask

    task automatic drain_a();
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
        chk("a_drain_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a_tab[0] = '{1'b1, 32'h07, 32'h05};
        a_tab[1] = '{1'b1, 32'h80, 32'hFF};
        a_tab[2] = '{1'b1, 32'hC0, 32'h80};
        a_tab[3] = '{1'b0, 32'hA5, 32'hF7};
        a_tab[4] = '{1'b1, 32'hFF, 32'hAA};
        a_tab[5] = '{1'b0, 32'h80, 32'hC0};
        a_tab[6] = '{1'b1, 32'h01, 32'h01};
        a_tab[7] = '{1'b0, 32'h7F, 32'h40};
        a_tab[8] = '{1'b1, 32'h55, 32'h66};
        c_tab[0] = '{1'b0, 32'h0, 32'h0};
        c_tab[1] = '{1'b0, 32'h1, 32'h1};
        c_tab[2] = '{1'b0, 32'h2, 32'h3};
        c_tab[3] = '{1'b0, 32'h3, 32'h2};
        c_tab[4] = '{1'b1, 32'h0, 32'h0};
        c_tab[5] = '{1'b1, 32'h1, 32'h1};
        c_tab[6] = '{1'b1, 32'h2, 32'h3};
        c_tab[7] = '{1'b1, 32'h3, 32'h2};

        rst_n = 1'b0;
        a_en = 0; a_mode = 0; a_data = '0; a_rdy = 1;
        b_en = 0; b_mode = 0; b_data = '0; b_rdy = 1;
        c_en = 0; c_mode = 0; c_data = '0; c_rdy = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_a_vld", a_vld, 0);
        chk("rst_a_data", a_odata, 0);
        chk("rst_a_mode", a_omode, 0);
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_a_rdy", a_ordy, 1);
        chk("rst_b_vld", b_vld, 0);
        chk("rst_b_cnt", b_cnt, 0);

        // Latency at PIPE=2: accept at edge E, visible after E+1, consecutive outputs.
        @(posedge clk); #1;
        a_en = 1; a_mode = 0; a_data = 8'h05;
        @(posedge clk); #1 a_data = 8'hFF;
        @(negedge clk); chk("lat_a_early_vld", a_vld, 0);
        @(posedge clk); #1 a_data = 8'h00;
        @(negedge clk); chk("lat_a_out0", {a_vld, a_odata}, {1'b1, 8'h07});
        @(posedge clk); #1 a_en = 0;
        @(negedge clk); chk("lat_a_out1", {a_vld, a_odata}, {1'b1, 8'h80});
        @(posedge clk);
        @(negedge clk); chk("lat_a_out2", {a_vld, a_odata}, {1'b1, 8'h00});
        @(posedge clk);
        @(negedge clk);
        chk("lat_a_idle_vld", a_vld, 0);
        chk("lat_a_cnt", a_cnt, 3);

        // Table of mixed-mode beats through the scoreboard.
        mon_on = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) send_a(a_tab[i].mode, a_tab[i].din[7:0], a_tab[i].dout[7:0], 1'b1);
        a_en = 0;
        drain_a();
        chk("tab_a_cnt", a_cnt, 12);

        // Alternate modes per beat over the full 8-bit range; each pair must round-trip.
        pulse_reset();
        for (int v = 0; v < 256; v++) begin
            send_a(1'b0, 8'(v), g8(8'(v)), 1'b1);
            send_a(1'b1, g8(8'(v)), 8'(v), 1'b1);
        end
        a_en = 0;
        drain_a();
        chk("rt_a_cnt", a_cnt, 512);

        // Stall mid-stream: five stalled cycles with 0x01 held on the output.
        pulse_reset();
        fork
            begin
                for (int i = 1; i <= 6; i++) send_a(1'b0, 8'(i), g8(8'(i)), 1'b1);
                a_en = 0;
            end
            begin
                @(posedge clk);
                @(posedge clk);
                #1 a_rdy = 0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_vld", a_vld, 1);
                    chk("stall_data", a_odata, 8'h01);
                    chk("stall_ordy", a_ordy, 0);
                    chk("stall_cnt", a_cnt, 0);
                    @(posedge clk);
                end
                #1 a_rdy = 1;
            end
        join
        drain_a();
        chk("stall_a_cnt", a_cnt, 6);

        // Reset with two beats in flight; nothing may emerge afterwards.
        a_rdy = 0;
        send_a(1'b0, 8'hAA, 8'h00, 1'b0);
        send_a(1'b0, 8'h55, 8'h00, 1'b0);
        a_en = 0;
        chk("mid_pre_vld", a_vld, 1);
        pulse_reset();
        a_rdy = 1;
        @(negedge clk);
        chk("mid_rst_vld", a_vld, 0);
        chk("mid_rst_cnt", a_cnt, 0);
        chk("mid_rst_data", a_odata, 0);
        chk("mid_rst_mode", a_omode, 0);
        chk("mid_rst_rdy", a_ordy, 1);
        stale = 1'b0;
        repeat (6) begin
            @(negedge clk);
            stale = stale | a_vld;
        end
        chk("mid_no_stale", stale, 0);
        chk("mid_cnt_after", a_cnt, 0);
        mon_on = 1'b0;

        // 32-bit, PIPE=4: latency of 4, then stall and counter wrap at CNT_W=4.
        @(posedge clk); #1;
        b_rdy = 0;
        b_en = 1; b_mode = 1; b_data = 32'h8000_0000;
        @(posedge clk); #1 b_en = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b_lat_early_vld", b_vld, 0);
            @(posedge clk);
        end
        @(negedge clk);
        chk("b_out", {b_vld, b_omode, b_odata}, {1'b1, 1'b1, 32'hFFFF_FFFF});
        repeat (3) begin
            @(negedge clk);
            chk("b_stall_cnt", b_cnt, 0);
            chk("b_stall_data", {b_vld, b_odata}, {1'b1, 32'hFFFF_FFFF});
        end
        @(posedge clk); #1 b_rdy = 1;
        @(posedge clk);
        @(negedge clk);
        chk("b_cnt_one", b_cnt, 1);
        chk("b_vld_after", b_vld, 0);
        @(posedge clk); #1;
        b_en = 1; b_mode = 0;
        for (int i = 0; i < 16; i++) begin
            b_data = 32'(i);
            chk("b_stream_rdy", b_ordy, 1);
            @(posedge clk); #1;
        end
        b_en = 0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("b_cnt_wrap", b_cnt, 1);
        chk("b_last_data", b_odata, 32'h8);
        chk("b_idle_vld", b_vld, 0);

        // 2-bit, PIPE=1: every value in both modes, visible right after the accepting edge.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            c_en = 1; c_mode = c_tab[i].mode; c_data = c_tab[i].din[1:0];
            @(negedge clk);
            chk("c_pre_rdy", c_ordy, 1);
            chk("c_pre_vld", c_vld, 0);
            @(posedge clk); #1 c_en = 0;
            @(negedge clk);
            chk("c_out", {c_vld, c_omode, c_odata}, {1'b1, c_tab[i].mode, c_tab[i].dout[1:0]});
        end
        @(posedge clk);
        @(negedge clk);
        chk("c_cnt", c_cnt, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
